// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the core's write-back path and the multi-cycle RV32M unit.
// The core drives the request side; the unit drives busy/done/result.
interface mul_div_unit_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic            abort_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (output start_i, abort_i, funct3_i, a_i, b_i,
                  input  busy_o, done_o, result_o);
  modport slave  (input  start_i, abort_i, funct3_i, a_i, b_i,
                  output busy_o, done_o, result_o);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide: 1 bit per cycle shift-add multiply and restoring divide
// on operand magnitudes, with sign fix-up and RISC-V division special cases resolved at FIN.
module mul_div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          reset,
  mul_div_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_e;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e              state_q, state_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opb_q, opb_d;
  logic [2:0]          fn_q, fn_d;
  logic                neg_q, neg_d;
  logic                spec_q, spec_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                done_q, done_d;
  logic [XLEN-1:0]     res_q, res_d;

  // request decode, evaluated on the live inputs in IDLE
  logic            is_div, a_sgn, b_sgn, div_zero, div_ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, spec_val;

  always_comb begin
    is_div   = bus.funct3_i[2];
    a_sgn    = bus.a_i[XLEN-1] & (bus.funct3_i == 3'b001 || bus.funct3_i == 3'b010 ||
                                  bus.funct3_i == 3'b100 || bus.funct3_i == 3'b110);
    b_sgn    = bus.b_i[XLEN-1] & (bus.funct3_i == 3'b001 || bus.funct3_i == 3'b100 ||
                                  bus.funct3_i == 3'b110);
    a_mag    = a_sgn ? -bus.a_i : bus.a_i;
    b_mag    = b_sgn ? -bus.b_i : bus.b_i;
    div_zero = is_div & (bus.b_i == '0);
    div_ovf  = is_div & ~bus.funct3_i[0] & (bus.a_i == MIN_NEG) & (bus.b_i == '1);
    special  = div_zero | div_ovf;
    if (div_zero) spec_val = bus.funct3_i[1] ? bus.a_i : '1;
    else          spec_val = bus.funct3_i[1] ? '0 : bus.a_i;
  end

  // One iteration of each algorithm. The product shifts right with the multiplier in the low half;
  // the divide shifts left with the dividend in the low half and the partial remainder above it.
  logic [XLEN:0]     mul_sum, div_tmp, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next;
  logic              div_ge;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next = {mul_sum, acc_q[XLEN-1:1]};
    div_tmp  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_diff = div_tmp - {1'b0, opb_q};
    div_ge   = ~div_diff[XLEN];
    div_next = {(div_ge ? div_diff[XLEN-1:0] : div_tmp[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   q_or_r, fin_div, fin_mul, fin_val;

  always_comb begin
    prod    = neg_q ? -acc_q : acc_q;
    q_or_r  = fn_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    fin_div = neg_q ? -q_or_r : q_or_r;
    fin_mul = (fn_q[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    if (spec_q)       fin_val = acc_q[XLEN-1:0];
    else if (fn_q[2]) fin_val = fin_div;
    else              fin_val = fin_mul;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    opb_d   = opb_q;
    fn_d    = fn_q;
    neg_d   = neg_q;
    spec_d  = spec_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    res_d   = res_q;
    case (state_q)
      IDLE: if (bus.start_i) begin
        fn_d   = bus.funct3_i;
        cnt_d  = '0;
        spec_d = special;
        // remainder takes the dividend's sign; everything else the XOR of operand signs
        neg_d  = (is_div & bus.funct3_i[1]) ? a_sgn : (a_sgn ^ b_sgn);
        if (special) begin
          acc_d   = {{XLEN{1'b0}}, spec_val};
          opb_d   = '0;
          state_d = FIN;
        end else begin
          acc_d   = {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
          opb_d   = is_div ? b_mag : a_mag;
          state_d = CALC;
        end
      end
      CALC: begin
        if (bus.abort_i) begin
          state_d = IDLE;
        end else begin
          acc_d = fn_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(XLEN-1)) state_d = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
        if (!bus.abort_i) begin
          done_d = 1'b1;
          res_d  = fin_val;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      opb_q   <= '0;
      fn_q    <= '0;
      neg_q   <= 1'b0;
      spec_q  <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      opb_q   <= opb_d;
      fn_q    <= fn_d;
      neg_q   <= neg_d;
      spec_q  <= spec_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      res_q   <= res_d;
    end
  end

  assign bus.busy_o   = (state_q != IDLE);
  assign bus.done_o   = done_q;
  assign bus.result_o = res_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: results, latencies, start/abort handling and async reset.
module tb_mul_div_unit;
  logic clk;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  mul_div_unit_if #(.XLEN(32)) bus();

  mul_div_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request at #1 after a rising edge; returns the result and the number of edges
  // after the accepting edge until done_o is seen (-1 on timeout), plus busy cycles observed.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int bcyc);
    bus.funct3_i = f; bus.a_i = a; bus.b_i = b; bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0; bus.a_i = 32'h0; bus.b_i = 32'h0; bus.funct3_i = 3'b000;
    lat = -1; bcyc = 0; res = 32'hx;
    if (bus.busy_o) bcyc++;
    for (int n = 1; n <= 100 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (bus.done_o) begin lat = n; res = bus.result_o; end
      else if (bus.busy_o) bcyc++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.start_i = 1'b0; bus.abort_i = 1'b0; bus.funct3_i = 3'b0; bus.a_i = 32'h0; bus.b_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", bus.busy_o); end
    total++; if (bus.done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", bus.done_o); end
    total++; if (bus.result_o !== 32'h0) begin bad++; $display("FAIL reset_result got=%h want=0", bus.result_o); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    logic [31:0] r; int lat, bc;
    run_op(3'b000, 32'd7, 32'hFFFFFFFD, r, lat, bc);
    total++; if (r !== 32'hFFFFFFEB) begin bad++; $display("FAIL mul_res got=%h want=ffffffeb", r); end
    total++; if (lat !== 33) begin bad++; $display("FAIL mul_lat got=%0d want=33", lat); end
    total++; if (bc !== 33) begin bad++; $display("FAIL mul_busy got=%0d want=33", bc); end
    run_op(3'b001, 32'h80000000, 32'h80000000, r, lat, bc);
    total++; if (r !== 32'h40000000) begin bad++; $display("FAIL mulh_res got=%h want=40000000", r); end
    run_op(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, bc);
    total++; if (r !== 32'hFFFFFFFE) begin bad++; $display("FAIL mulhu_res got=%h want=fffffffe", r); end
    run_op(3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, r, lat, bc);
    total++; if (r !== 32'hFFFFFFFF) begin bad++; $display("FAIL mulhsu_res got=%h want=ffffffff", r); end
    run_op(3'b001, 32'hFFFFFFF9, 32'd3, r, lat, bc);
    total++; if (r !== 32'hFFFFFFFF) begin bad++; $display("FAIL mulh_neg_res got=%h want=ffffffff", r); end
  endtask

  task automatic test_div();
    logic [31:0] r; int lat, bc;
    run_op(3'b100, 32'hFFFFFFF9, 32'd2, r, lat, bc);
    total++; if (r !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_res got=%h want=fffffffd", r); end
    total++; if (lat !== 33) begin bad++; $display("FAIL div_lat got=%0d want=33", lat); end
    run_op(3'b110, 32'hFFFFFFF9, 32'd2, r, lat, bc);
    total++; if (r !== 32'hFFFFFFFF) begin bad++; $display("FAIL rem_res got=%h want=ffffffff", r); end
    run_op(3'b101, 32'd100, 32'd7, r, lat, bc);
    total++; if (r !== 32'd14) begin bad++; $display("FAIL divu_res got=%h want=0000000e", r); end
    run_op(3'b111, 32'd100, 32'd7, r, lat, bc);
    total++; if (r !== 32'd2) begin bad++; $display("FAIL remu_res got=%h want=00000002", r); end
  endtask

  task automatic test_special();
    logic [31:0] r; int lat, bc;
    run_op(3'b100, 32'd5, 32'd0, r, lat, bc);
    total++; if (r !== 32'hFFFFFFFF) begin bad++; $display("FAIL div0_res got=%h want=ffffffff", r); end
    total++; if (lat !== 1) begin bad++; $display("FAIL div0_lat got=%0d want=1", lat); end
    run_op(3'b110, 32'd5, 32'd0, r, lat, bc);
    total++; if (r !== 32'd5) begin bad++; $display("FAIL rem0_res got=%h want=00000005", r); end
    total++; if (lat !== 1) begin bad++; $display("FAIL rem0_lat got=%0d want=1", lat); end
    run_op(3'b100, 32'h80000000, 32'hFFFFFFFF, r, lat, bc);
    total++; if (r !== 32'h80000000) begin bad++; $display("FAIL divovf_res got=%h want=80000000", r); end
    total++; if (lat !== 1) begin bad++; $display("FAIL divovf_lat got=%0d want=1", lat); end
    run_op(3'b110, 32'h80000000, 32'hFFFFFFFF, r, lat, bc);
    total++; if (r !== 32'h0) begin bad++; $display("FAIL removf_res got=%h want=00000000", r); end
    total++; if (lat !== 1) begin bad++; $display("FAIL removf_lat got=%0d want=1", lat); end
    run_op(3'b101, 32'd9, 32'd0, r, lat, bc);
    total++; if (r !== 32'hFFFFFFFF) begin bad++; $display("FAIL divu0_res got=%h want=ffffffff", r); end
  endtask

  task automatic test_start_hold();
    int dones = 0;
    logic [31:0] r = 32'h0;
    bus.funct3_i = 3'b101; bus.a_i = 32'd100; bus.b_i = 32'd7; bus.start_i = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (bus.done_o) begin dones++; r = bus.result_o; end
    end
    bus.start_i = 1'b0;
    total++; if (dones !== 1) begin bad++; $display("FAIL hold_dones got=%0d want=1", dones); end
    total++; if (r !== 32'd14) begin bad++; $display("FAIL hold_res got=%h want=0000000e", r); end
    // the held start re-issued the request after done; cancel it
    bus.abort_i = 1'b1; @(posedge clk); #1; bus.abort_i = 1'b0;
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL hold_drain_busy got=%b want=0", bus.busy_o); end
  endtask

  task automatic test_start_ignored();
    int lat = -1;
    logic [31:0] r = 32'h0;
    bus.funct3_i = 3'b101; bus.a_i = 32'd100; bus.b_i = 32'd7; bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    for (int n = 1; n <= 100 && lat < 0; n++) begin
      if (n == 5) begin bus.funct3_i = 3'b000; bus.a_i = 32'd3; bus.b_i = 32'd3; bus.start_i = 1'b1; end
      else bus.start_i = 1'b0;
      @(posedge clk); #1;
      if (bus.done_o) begin lat = n; r = bus.result_o; end
    end
    bus.start_i = 1'b0;
    total++; if (r !== 32'd14) begin bad++; $display("FAIL ign_res got=%h want=0000000e", r); end
    total++; if (lat !== 33) begin bad++; $display("FAIL ign_lat got=%0d want=33", lat); end
  endtask

  task automatic test_abort();
    int dones = 0;
    bus.funct3_i = 3'b000; bus.a_i = 32'd7; bus.b_i = 32'hFFFFFFFD; bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (10) @(posedge clk);
    #1; bus.abort_i = 1'b1;
    @(posedge clk); #1; bus.abort_i = 1'b0;
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", bus.busy_o); end
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (bus.done_o) dones++;
    end
    total++; if (dones !== 0) begin bad++; $display("FAIL abort_dones got=%0d want=0", dones); end
    total++; if (bus.result_o !== 32'd14) begin bad++; $display("FAIL abort_hold got=%h want=0000000e", bus.result_o); end
  endtask

  task automatic test_async_reset();
    bus.funct3_i = 3'b100; bus.a_i = 32'd50; bus.b_i = 32'd5; bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    repeat (5) @(posedge clk);
    #2; reset = 1'b0;
    #1;
    total++; if (bus.busy_o !== 1'b0) begin bad++; $display("FAIL arst_busy got=%b want=0", bus.busy_o); end
    total++; if (bus.result_o !== 32'h0) begin bad++; $display("FAIL arst_result got=%h want=0", bus.result_o); end
    total++; if (bus.done_o !== 1'b0) begin bad++; $display("FAIL arst_done got=%b want=0", bus.done_o); end
    @(posedge clk); #1; reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r; int lat, bc;
    run_op(3'b101, 32'd1000, 32'd10, r, lat, bc);
    total++; if (r !== 32'd100) begin bad++; $display("FAIL b2b_divu got=%h want=00000064", r); end
    run_op(3'b000, 32'd12345, 32'd100, r, lat, bc);
    total++; if (r !== 32'd1234500) begin bad++; $display("FAIL b2b_mul got=%h want=0012d644", r); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_start_hold();
    test_start_ignored();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
